// File: rtl/pmp_walk_checker.sv
// Sequential PMP/DMP (JITDomain) checker: walks NR_ENTRIES entries, ENTRIES_PER_CYCLE per cycle.
// Optional one-entry last-result cache under `PMP_WALK_LAST_HIT_CACHE_EN.
module pmp_walk_checker #(
  parameter int unsigned PLEN              = 34,
  parameter int unsigned PMP_LEN           = 32,
  parameter int unsigned NR_ENTRIES        = 16,
  parameter int unsigned ENTRIES_PER_CYCLE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PLEN-1:0]      req_addr_i,
  input  logic [2:0]           req_access_i,
  input  logic [1:0]           req_priv_i,
  input  logic [3:0]           req_dom_i,
  input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)-1:0][PMP_LEN-1:0] conf_addr_i,
  input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)-1:0][7:0]         pmpconf_i,
  input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)-1:0][4:0]         dmpconf_i,
  input  logic                 cfg_flush_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_allow_o,
  output logic                 rsp_match_o,
  output logic [((NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1)-1:0] rsp_idx_o,
  output logic                 rsp_dom_fault_o,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: a request transfers on the edge where req_valid_i && req_ready_o;
  // a response transfers on the edge where rsp_valid_o && rsp_ready_i. Outputs hold until then.
  // Encodings: access {x,w,r}; priv M=3; pmpconf {L,rsvd[1:0],A[1:0],xwr}; dmpconf {L,domain[3:0]}.
  localparam int          IW         = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int          NG         = (NR_ENTRIES > 0) ? NR_ENTRIES / ENTRIES_PER_CYCLE : 1;
  localparam int          GW         = (NG > 1) ? $clog2(NG) : 1;
  localparam int          CW         = (PMP_LEN + 2 > PLEN) ? PMP_LEN + 2 : PLEN;
  localparam int          TW         = PLEN - 2 + 3 + 2 + 4;
  localparam logic [GW-1:0] LAST_GROUP = GW'(NG - 1);
  localparam logic [1:0]  PRIV_M     = 2'b11;
  localparam logic [3:0]  DOMI       = 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_next;
  logic [PLEN-1:0] cap_addr;
  logic [2:0]      cap_access;
  logic [1:0]      cap_priv;
  logic [3:0]      cap_dom;
  logic [GW-1:0]   group;
  logic            res_allow, res_match, res_dom_fault;
  logic [IW-1:0]   res_idx;
  logic            grp_hit, grp_allow, grp_dom_fault;
  logic [IW-1:0]   grp_idx;
  logic            cache_hit;
  logic            walk_done;
  logic            walk_allow;
  logic            unused_cfg;

  assign unused_cfg = ^pmpconf_i;

  // TOR compares byte addresses; NA4/NAPOT compare word addresses under a trailing-ones mask.
  function automatic logic entry_match(input logic [PLEN-1:0] addr, input logic [1:0] mode,
                                       input logic [PMP_LEN-1:0] cur, input logic [PMP_LEN-1:0] prev);
    logic [CW-1:0]      a, lo, hi, wa, wc, mask;
    logic [PMP_LEN-1:0] m;
    a  = CW'(addr);
    lo = CW'({prev, 2'b00});
    hi = CW'({cur, 2'b00});
    wa = a >> 2;
    wc = CW'(cur);
    m  = cur ^ (cur + 1'b1);
    mask = CW'(m);
    case (mode)
      2'b01:   entry_match = (a >= lo) && (a < hi);
      2'b10:   entry_match = (wa == wc);
      2'b11:   entry_match = ((wa & ~mask) == (wc & ~mask));
      default: entry_match = 1'b0;
    endcase
  endfunction

  // Evaluate the current group; iterating downward leaves the lowest applicable hit in place.
  always_comb begin : group_eval
    logic [IW-1:0]      eidx;
    logic [PMP_LEN-1:0] prev;
    logic [7:0]         pc;
    logic [4:0]         dc;
    logic               applicable, perm_ok, dom_ok;
    grp_hit       = 1'b0;
    grp_idx       = '0;
    grp_allow     = 1'b0;
    grp_dom_fault = 1'b0;
    for (int k = ENTRIES_PER_CYCLE - 1; k >= 0; k--) begin
      eidx       = IW'(int'(group) * ENTRIES_PER_CYCLE + k);
      prev       = (eidx == '0) ? '0 : conf_addr_i[eidx - 1'b1];
      pc         = pmpconf_i[eidx];
      dc         = dmpconf_i[eidx];
      applicable = (cap_priv != PRIV_M) || (pc[7] && dc[4]);
      perm_ok    = ((cap_access & ~pc[2:0]) == 3'b000);
      dom_ok     = (dc[3:0] == DOMI) || (cap_dom == DOMI) || (cap_dom == dc[3:0]);
      if (applicable && entry_match(cap_addr, pc[4:3], conf_addr_i[eidx], prev)) begin
        grp_hit       = 1'b1;
        grp_idx       = eidx;
        grp_allow     = perm_ok && dom_ok;
        grp_dom_fault = perm_ok && !dom_ok;
      end
    end
  end

  assign walk_done  = (state == WALK) && !cfg_flush_i && (grp_hit || group == LAST_GROUP);
  assign walk_allow = grp_hit ? grp_allow : (cap_priv == PRIV_M);

`ifdef PMP_WALK_LAST_HIT_CACHE_EN
  logic          cache_valid;
  logic [TW-1:0] cache_tag;
  logic          cache_allow, cache_match, cache_dom_fault;
  logic [IW-1:0] cache_idx;

  assign cache_hit = cache_valid && !cfg_flush_i &&
                     (cache_tag == {req_addr_i[PLEN-1:2], req_access_i, req_priv_i, req_dom_i});

  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_flush_i) begin
      cache_valid <= 1'b0;
    end else if (walk_done) begin
      cache_valid     <= 1'b1;
      cache_tag       <= {cap_addr[PLEN-1:2], cap_access, cap_priv, cap_dom};
      cache_allow     <= walk_allow;
      cache_match     <= grp_hit;
      cache_idx       <= grp_hit ? grp_idx : '0;
      cache_dom_fault <= grp_hit && grp_dom_fault;
    end
  end
`else
  logic [TW-1:0] unused_tag;
  assign unused_tag = '0;
  assign cache_hit  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid_i) state_next = (NR_ENTRIES == 0 || cache_hit) ? RESP : WALK;
      WALK:    if (walk_done)   state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = (state == IDLE);
    rsp_valid_o     = (state == RESP);
    rsp_allow_o     = rsp_valid_o && res_allow;
    rsp_match_o     = rsp_valid_o && res_match;
    rsp_idx_o       = rsp_valid_o ? res_idx : '0;
    rsp_dom_fault_o = rsp_valid_o && res_dom_fault;
    dbg_state_o     = state;
  end

  // A flush in WALK restarts from group 0 and beats any decision made in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_addr      <= '0;
      cap_access    <= '0;
      cap_priv      <= '0;
      cap_dom       <= '0;
      group         <= '0;
      res_allow     <= 1'b0;
      res_match     <= 1'b0;
      res_idx       <= '0;
      res_dom_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          cap_addr   <= req_addr_i;
          cap_access <= req_access_i;
          cap_priv   <= req_priv_i;
          cap_dom    <= req_dom_i;
          group      <= '0;
          if (NR_ENTRIES == 0) begin
            res_allow     <= 1'b1;
            res_match     <= 1'b0;
            res_idx       <= '0;
            res_dom_fault <= 1'b0;
          end else if (cache_hit) begin
`ifdef PMP_WALK_LAST_HIT_CACHE_EN
            res_allow     <= cache_allow;
            res_match     <= cache_match;
            res_idx       <= cache_idx;
            res_dom_fault <= cache_dom_fault;
`endif
          end
        end
        WALK: begin
          if (cfg_flush_i) begin
            group <= '0;
          end else if (walk_done) begin
            res_allow     <= walk_allow;
            res_match     <= grp_hit;
            res_idx       <= grp_hit ? grp_idx : '0;
            res_dom_fault <= grp_hit && grp_dom_fault;
          end else begin
            group <= group + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_walk_checker.sv
// Directed bench for pmp_walk_checker (16 entries, 4 per cycle); cache steps run when
// PMP_WALK_LAST_HIT_CACHE_EN is defined. Edge 0 is the edge before req_valid is driven.
module tb_pmp_walk_checker;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [33:0]       req_addr;
  logic [2:0]        req_access;
  logic [1:0]        req_priv;
  logic [3:0]        req_dom;
  logic [15:0][31:0] conf_addr;
  logic [15:0][7:0]  pmpconf;
  logic [15:0][4:0]  dmpconf;
  logic              cfg_flush;
  logic              rsp_valid, rsp_ready, rsp_allow, rsp_match, rsp_dom_fault;
  logic [3:0]        rsp_idx;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  pmp_walk_checker #(.PLEN(34), .PMP_LEN(32), .NR_ENTRIES(16), .ENTRIES_PER_CYCLE(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_access_i(req_access), .req_priv_i(req_priv), .req_dom_i(req_dom),
    .conf_addr_i(conf_addr), .pmpconf_i(pmpconf), .dmpconf_i(dmpconf),
    .cfg_flush_i(cfg_flush),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_allow_o(rsp_allow), .rsp_match_o(rsp_match), .rsp_idx_o(rsp_idx),
    .rsp_dom_fault_o(rsp_dom_fault), .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits #1 after edge 0; returns once rsp_valid is seen (lat = edges after edge 0).
  task automatic run_req(input logic [33:0] addr, input logic [2:0] acc, input logic [1:0] priv,
                         input logic [3:0] dom, input int flush_at, output int l);
    req_addr = addr; req_access = acc; req_priv = priv; req_dom = dom;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = 1;
    cfg_flush = (flush_at == 1);
    while (!rsp_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
      cfg_flush = (l == flush_at);
    end
    cfg_flush = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int l, input int exp_lat, input logic allow,
                            input logic match, input logic [3:0] idx, input logic df);
    check({tag, ".lat"},   l,             exp_lat);
    check({tag, ".allow"}, rsp_allow,     allow);
    check({tag, ".match"}, rsp_match,     match);
    check({tag, ".idx"},   rsp_idx,       idx);
    check({tag, ".df"},    rsp_dom_fault, df);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, ".done_valid"}, rsp_valid, 1'b0);
    check({tag, ".done_ready"}, req_ready, 1'b1);
  endtask

  task automatic pulse_flush();
    cfg_flush = 1'b1;
    @(posedge clk); #1;
    cfg_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_access = '0; req_priv = '0; req_dom = '0;
    cfg_flush = 1'b0; rsp_ready = 1'b0;
    conf_addr = '0; pmpconf = '0; dmpconf = '0;
    conf_addr[1]  = 32'h2C00_01FF; pmpconf[1]  = 8'h99;                        // 0xB000_0000 4K R, locked
    conf_addr[2]  = 32'h2800_01FF; pmpconf[2]  = 8'h1B; dmpconf[2] = 5'h03;    // 0xA000_0000 4K RW, dom 3
    conf_addr[5]  = 32'h2000_01FF; pmpconf[5]  = 8'h1B;                        // 0x8000_0000 4K RW
    conf_addr[7]  = 32'h3000_0000;                                             // TOR base, OFF
    conf_addr[8]  = 32'h3000_0400; pmpconf[8]  = 8'h0F;                        // TOR 0xC000_0000..0FFF RWX
    conf_addr[12] = 32'h3400_0000; pmpconf[12] = 8'h13;                        // NA4 0xD000_0000 RW
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", rsp_valid, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.allow", rsp_allow, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle.ready", req_ready, 1'b1);
    check("idle.idx",   rsp_idx,   4'd0);

    run_req(34'h0_8000_0010, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("napot5", lat, 3, 1'b1, 1'b1, 4'd5, 1'b0);
    handshake("napot5");

    run_req(34'h0_9000_0000, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("nomatch_u", lat, 5, 1'b0, 1'b0, 4'd0, 1'b0);
    handshake("nomatch_u");

    run_req(34'h0_9000_0000, 3'b001, 2'd3, 4'd1, 0, lat);
    expect_rsp("nomatch_m", lat, 5, 1'b1, 1'b0, 4'd0, 1'b0);
    handshake("nomatch_m");

    run_req(34'h0_A000_0100, 3'b001, 2'd0, 4'd4, 0, lat);
    expect_rsp("dom_miss", lat, 2, 1'b0, 1'b1, 4'd2, 1'b1);
    handshake("dom_miss");

    run_req(34'h0_A000_0100, 3'b001, 2'd0, 4'd0, 0, lat);
    expect_rsp("dom_domi", lat, 2, 1'b1, 1'b1, 4'd2, 1'b0);
    handshake("dom_domi");

    run_req(34'h0_A000_0100, 3'b001, 2'd0, 4'd3, 0, lat);
    expect_rsp("dom_same", lat, 2, 1'b1, 1'b1, 4'd2, 1'b0);
    handshake("dom_same");

    run_req(34'h0_A000_0100, 3'b100, 2'd0, 4'd4, 0, lat);
    expect_rsp("perm_and_dom", lat, 2, 1'b0, 1'b1, 4'd2, 1'b0);
    handshake("perm_and_dom");

    run_req(34'h0_B000_0000, 3'b001, 2'd3, 4'd1, 0, lat);
    expect_rsp("m_half_lock", lat, 5, 1'b1, 1'b0, 4'd0, 1'b0);
    handshake("m_half_lock");

    dmpconf[1] = 5'h10;
    pulse_flush();
    run_req(34'h0_B000_0004, 3'b010, 2'd3, 4'd1, 0, lat);
    expect_rsp("m_locked_wr", lat, 2, 1'b0, 1'b1, 4'd1, 1'b0);
    handshake("m_locked_wr");

    run_req(34'h0_B000_0004, 3'b001, 2'd3, 4'd1, 0, lat);
    expect_rsp("m_locked_rd", lat, 2, 1'b1, 1'b1, 4'd1, 1'b0);
    handshake("m_locked_rd");

    run_req(34'h0_C000_0FFC, 3'b100, 2'd0, 4'd1, 0, lat);
    expect_rsp("tor_top", lat, 4, 1'b1, 1'b1, 4'd8, 1'b0);
    handshake("tor_top");

    run_req(34'h0_C000_1000, 3'b100, 2'd0, 4'd1, 0, lat);
    expect_rsp("tor_end", lat, 5, 1'b0, 1'b0, 4'd0, 1'b0);
    handshake("tor_end");

    run_req(34'h0_D000_0003, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("na4_in", lat, 5, 1'b1, 1'b1, 4'd12, 1'b0);
    handshake("na4_in");

    run_req(34'h0_D000_0004, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("na4_out", lat, 5, 1'b0, 1'b0, 4'd0, 1'b0);
    handshake("na4_out");

    // Flush while group 2 is being walked: three extra edges, then hold the response.
    run_req(34'h0_9000_0004, 3'b001, 2'd0, 4'd1, 3, lat);
    expect_rsp("flush_walk", lat, 8, 1'b0, 1'b0, 4'd0, 1'b0);
    req_addr = 34'h0_8000_0010; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hold.valid", rsp_valid, 1'b1);
      check("hold.ready", req_ready, 1'b0);
      check("hold.allow", rsp_allow, 1'b0);
      check("hold.match", rsp_match, 1'b0);
    end
    handshake("hold");

    // Reset in the middle of a walk drops it.
    req_addr = 34'h0_9000_0000; req_access = 3'b001; req_priv = 2'd0; req_dom = 4'd1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midwalk.busy", req_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwalk.valid", rsp_valid, 1'b0);
    check("midwalk.ready", req_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midwalk.idle", dbg_state, 2'd0);

`ifdef PMP_WALK_LAST_HIT_CACHE_EN
    run_req(34'h0_8000_0010, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("cache_fill", lat, 3, 1'b1, 1'b1, 4'd5, 1'b0);
    handshake("cache_fill");
    run_req(34'h0_8000_0010, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("cache_hit", lat, 1, 1'b1, 1'b1, 4'd5, 1'b0);
    handshake("cache_hit");
    pulse_flush();
    run_req(34'h0_8000_0010, 3'b001, 2'd0, 4'd1, 0, lat);
    expect_rsp("cache_flushed", lat, 3, 1'b1, 1'b1, 4'd5, 1'b0);
    handshake("cache_flushed");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_walk_checker.md
Name: pmp_walk_checker

Overview:
- Sequential, parametrised successor to the combinational PMP/DMP (JITDomain) checker.
- Walks NR_ENTRIES PMP entries, ENTRIES_PER_CYCLE at a time, trading latency for area, so entry counts up to 64 are practical.
- Request/response valid-ready handshake; reports the matched entry and the denial cause.
- Sits between the MMU/LSU request path and memory; one check in flight at a time.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration, passed to pmp_entry.
- PLEN, 34: physical address width.
- PMP_LEN, 32: pmpaddr register width.
- NR_ENTRIES, 16: number of PMP/DMP entries; legal range 0..64.
- ENTRIES_PER_CYCLE, 4: entries evaluated per WALK cycle; must divide NR_ENTRIES.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  check request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  PLEN  physical address.
- req_access_i  in  riscv::pmp_access_t  access type.
- req_priv_i  in  riscv::priv_lvl_t  privilege level.
- req_dom_i  in  riscv::dmp_domain_t  current JITDomain.
- conf_addr_i  in  NR_ENTRIES x PMP_LEN  pmpaddr values.
- pmpconf_i  in  NR_ENTRIES x riscv::pmpcfg_t  PMP configs.
- dmpconf_i  in  NR_ENTRIES x riscv::dmpcfg_t  DMP configs.
- cfg_flush_i  in  1  config-change pulse.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_allow_o  out  1  access permitted.
- rsp_match_o  out  1  an applicable entry matched.
- rsp_idx_o  out  max(1,$clog2(NR_ENTRIES))  matched entry index; 0 if none.
- rsp_dom_fault_o  out  1  denied by domain mismatch only.

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; all rsp_* outputs 0; req_ready_o 1 after reset. Reset mid-walk or mid-response drops the transaction.
- FSM IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture addr/access/priv/dom, set group=0, go to WALK.
  - If NR_ENTRIES==0, go directly to RESP with allow=1, match=0.
- FSM WALK:
  - req_ready_o=0.
  - Evaluate entries group*EPC .. group*EPC+EPC-1 using EPC pmp_entry instances muxed on group (TOR prev address = conf_addr[i-1], or 0 for i=0).
  - Entry i is applicable if priv!=M or (pmpconf[i].locked and dmpconf[i].locked).
  - The lowest-indexed applicable matching entry decides:
    - rsp_allow = access subset of pmpconf[i].access_type AND domain ok.
    - Domain ok when dmpconf.domain==DOMI, or req_dom==DOMI, or req_dom==dmpconf.domain.
    - rsp_match=1; rsp_idx=i.
    - rsp_dom_fault=1 iff the access bits pass and the domain check fails.
  - On a decision, go to RESP.
  - No decision and last group: rsp_match=0, rsp_idx=0, rsp_allow=(priv==M); go to RESP.
  - Otherwise group++.
- FSM RESP:
  - rsp_valid_o=1; outputs held stable until rsp_ready_i; then go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Latency: request accepted at edge 0, deciding group g → rsp_valid_o high after edge g+2. Worst case is NR_ENTRIES/EPC+1 edges.
- Config inputs are sampled live during WALK and must be stable.
- cfg_flush_i:
  - In WALK: group resets to 0 (walk restarts).
  - In IDLE or RESP: no effect on the captured request or the held result.
- Simultaneous cfg_flush_i and a deciding group: the flush wins; no decision is taken and the walk restarts.

Optional Feature:
- Macro PMP_WALK_LAST_HIT_CACHE_EN.
- Defined:
  - One-entry cache of the last result, tagged by {addr[PLEN-1:2], access, priv, dom}.
  - An IDLE request with a tag hit goes straight to RESP; rsp_valid_o is high after edge 1.
  - The cache fills on every walk completion.
  - Invalidated by rst_i and by cfg_flush_i in any state; a flush during WALK also prevents that walk's fill.
- Undefined: no cache; every request walks.

Test Plan:
- NR_ENTRIES=16, EPC=4, entry 5 NAPOT 0x8000_0000/4KiB RW, U-mode read 0x8000_0010 → rsp_valid after edge 3, allow=1, match=1, idx=5.
- Same config, U-mode read 0x9000_0000 (no match) → rsp_valid after edge 5, allow=0, match=0, idx=0; same access from M-mode → allow=1.
- Entry 2 domain=3, U-mode req_dom=4 read of a matching RW address → allow=0, dom_fault=1, idx=2; req_dom=DOMI → allow=1.
- M-mode access hitting entry 1 with pmp locked=1, dmp locked=0 → entry skipped, no match, allow=1; both locks set and R-only with write → allow=0, dom_fault=0.
- Pulse cfg_flush_i in WALK group 2 → walk restarts at group 0, response delayed 3 extra edges; hold rsp_ready_i=0 for 4 cycles → outputs stable, req_ready_o=0.
- With PMP_WALK_LAST_HIT_CACHE_EN: repeat an identical request → response after edge 1. Flush, then repeat → full walk latency. Assert rst_i mid-walk → rsp_valid_o=0 and req_ready_o=1 on the next cycle.
